// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage that sits directly after execute. Non-memory
// instructions pass straight through to the MEM/WB register. Aligned loads and
// stores are issued on a req/ack data-memory bus, and the pipeline stalls
// while an access is outstanding. Misaligned accesses never reach the bus.
// An access with no ack after WAIT_LIMIT wait cycles is abandoned.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no access outstanding; inputs sampled, non-mem ops retire
// S_WAIT | request on the bus, bus outputs frozen, waiting for dmem_ack
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid .. mem_unsigned      execute results and MEM/WB controls
//   dmem_req/we/addr/be/wdata     registered data-memory request
//   dmem_rdata, dmem_ack          data-memory response
//   mem_stall                     combinational upstream freeze
//   wb_valid/regwrite/writereg/wdata   registered MEM/WB entry
//   mem_misalign, mem_timeout     one-cycle fault pulses with the wb entry
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  writereg,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_writereg,
    output logic [31:0] wb_wdata,
    output logic        mem_misalign,
    output logic        mem_timeout
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_writereg_q, wb_writereg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    // Instruction captured at request issue
    logic        op_store_q, op_store_d;
    logic [1:0]  op_size_q, op_size_d;
    logic [1:0]  op_lane_q, op_lane_d;
    logic        op_unsigned_q, op_unsigned_d;
    logic        op_regwrite_q, op_regwrite_d;
    logic        op_memtoreg_q, op_memtoreg_d;
    logic [4:0]  op_writereg_q, op_writereg_d;
    logic [31:0] op_alu_q, op_alu_d;

    logic        is_mem, misaligned, issue, timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

    // Size 11 behaves as a word everywhere, so mem_size[1] alone marks a word.
    assign is_mem      = memread | memwrite;
    assign misaligned  = ((mem_size == 2'b01) & alu_result[0]) |
                         (mem_size[1] & (alu_result[1:0] != 2'b00));
    assign issue       = (state_q == S_IDLE) & in_valid & is_mem & ~misaligned;
    // Down-counter loaded at issue; reaching zero without ack ends the wait.
    assign timeout_hit = (state_q == S_WAIT) & ~dmem_ack & (cnt_q == '0);
    assign mem_stall   = issue | ((state_q == S_WAIT) & ~dmem_ack & ~timeout_hit);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        if (mem_size == 2'b00) begin
            st_be    = 4'b0001 << alu_result[1:0];
            st_wdata = {4{store_data[7:0]}};
        end else if (mem_size == 2'b01) begin
            st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{store_data[15:0]}};
        end
    end

    assign rd_shift = dmem_rdata >> {op_lane_q, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = op_lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_data = dmem_rdata;
        if (op_size_q == 2'b00) begin
            ld_data = {{24{rd_byte[7] & ~op_unsigned_q}}, rd_byte};
        end else if (op_size_q == 2'b01) begin
            ld_data = {{16{rd_half[15] & ~op_unsigned_q}}, rd_half};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_writereg_d = wb_writereg_q;
        wb_wdata_d    = wb_wdata_q;
        misalign_d    = 1'b0;
        timeout_d     = 1'b0;
        op_store_d    = op_store_q;
        op_size_d     = op_size_q;
        op_lane_d     = op_lane_q;
        op_unsigned_d = op_unsigned_q;
        op_regwrite_d = op_regwrite_q;
        op_memtoreg_d = op_memtoreg_q;
        op_writereg_d = op_writereg_q;
        op_alu_d      = op_alu_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_regwrite_d = regwrite;
                        wb_writereg_d = writereg;
                        wb_wdata_d    = alu_result;
                    end else if (misaligned) begin
                        wb_valid_d    = 1'b1;
                        misalign_d    = 1'b1;
                        wb_writereg_d = writereg;
                        wb_wdata_d    = alu_result;
                    end else begin
                        state_d       = S_WAIT;
                        cnt_d         = CW'(WAIT_LIMIT - 1);
                        req_d         = 1'b1;
                        we_d          = memwrite;
                        addr_d        = {alu_result[31:2], 2'b00};
                        be_d          = memwrite ? st_be : 4'b0000;
                        wdata_d       = memwrite ? st_wdata : 32'h0;
                        op_store_d    = memwrite;
                        op_size_d     = mem_size;
                        op_lane_d     = alu_result[1:0];
                        op_unsigned_d = mem_unsigned;
                        op_regwrite_d = regwrite;
                        op_memtoreg_d = memtoreg;
                        op_writereg_d = writereg;
                        op_alu_d      = alu_result;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_d       = S_IDLE;
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = op_regwrite_q & ~op_store_q;
                    wb_writereg_d = op_writereg_q;
                    wb_wdata_d    = (op_memtoreg_q & ~op_store_q) ? ld_data : op_alu_q;
                end else if (timeout_hit) begin
                    state_d       = S_IDLE;
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    timeout_d     = 1'b1;
                    wb_writereg_d = op_writereg_q;
                    wb_wdata_d    = op_alu_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_writereg_q <= '0;
            wb_wdata_q    <= '0;
            misalign_q    <= 1'b0;
            timeout_q     <= 1'b0;
            op_store_q    <= 1'b0;
            op_size_q     <= '0;
            op_lane_q     <= '0;
            op_unsigned_q <= 1'b0;
            op_regwrite_q <= 1'b0;
            op_memtoreg_q <= 1'b0;
            op_writereg_q <= '0;
            op_alu_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_writereg_q <= wb_writereg_d;
            wb_wdata_q    <= wb_wdata_d;
            misalign_q    <= misalign_d;
            timeout_q     <= timeout_d;
            op_store_q    <= op_store_d;
            op_size_q     <= op_size_d;
            op_lane_q     <= op_lane_d;
            op_unsigned_q <= op_unsigned_d;
            op_regwrite_q <= op_regwrite_d;
            op_memtoreg_q <= op_memtoreg_d;
            op_writereg_q <= op_writereg_d;
            op_alu_q      <= op_alu_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_writereg  = wb_writereg_q;
    assign wb_wdata     = wb_wdata_q;
    assign mem_misalign = misalign_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute results (ALU result/address, forwarded store data, destination register) plus MEM/WB control bits.
- Performs loads and stores over a variable-latency req/ack data-memory bus, stalling the pipeline while an access is outstanding.
- Drives the registered MEM/WB outputs consumed by writeback and by the forwarding path (memwb_wdata).

Parameters:
- WAIT_LIMIT, 255: max cycles in WAIT without dmem_ack before the access is abandoned (timeout); counter width = clog2(WAIT_LIMIT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute-stage output holds a valid instruction this cycle
- alu_result  in  32  ALU result / effective address
- store_data  in  32  forwarded rt value for stores
- writereg  in  5  destination register
- regwrite  in  1  instruction writes register file
- memtoreg  in  1  writeback data comes from memory
- memread  in  1  load
- memwrite  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_unsigned  in  1  zero-extend loads (lbu/lhu)
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  {alu_result[31:2],2'b00}, registered
- dmem_be  out  4  byte enables, registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete
- mem_stall  out  1  combinational; freezes all upstream stages this cycle
- wb_valid  out  1  MEM/WB entry valid
- wb_regwrite  out  1  write enable to register file
- wb_writereg  out  5  destination register
- wb_wdata  out  32  writeback data (also memwb_wdata for forwarding)
- mem_misalign  out  1  one-cycle pulse with the faulting instruction's wb entry
- mem_timeout  out  1  one-cycle pulse with the abandoned instruction's wb entry

Behaviour:
- Reset: state IDLE, wait counter 0; every registered output (dmem_*, wb_*, mem_misalign, mem_timeout) = 0; mem_stall = 0.
- mem_op = in_valid & (memread | memwrite). memwrite has priority if both are set (store; no load data).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No bus access, no stall. Next edge: wb_valid=1, wb_regwrite=0, mem_misalign=1.
- Non-memory op (in_valid, !mem_op): no stall. Next edge: wb_valid=1, wb_regwrite=regwrite, wb_wdata=alu_result, wb_writereg=writereg.
- in_valid=0 and not stalling: next edge wb_valid=0, wb_regwrite=0.
- FSM states IDLE and WAIT.
  - IDLE + aligned mem_op: mem_stall=1. At the edge, load dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata, clear the counter, go to WAIT. wb_valid=0 at that edge (bubble).
  - WAIT: bus outputs held stable until ack. mem_stall = !dmem_ack. An ack in the first WAIT cycle is legal.
  - WAIT + dmem_ack: at the edge, dmem_req=0, go to IDLE, register the wb entry. Upstream advances at the same edge. Minimum memory-op cost: 1 stall cycle.
  - WAIT, no ack, counter == WAIT_LIMIT-1: at the edge, dmem_req=0, go to IDLE, wb_valid=1, wb_regwrite=0, mem_timeout=1. mem_stall=0 in that cycle.
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{store_data[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{store_data[15:0]}}
  - word: be = 1111, wdata = store_data
  - Stores: wb_regwrite=0.
- Load extract: byte lane addr[1:0] or half lane addr[1] of dmem_rdata; sign-extend unless mem_unsigned. wb_wdata = memtoreg ? extracted : alu_result; wb_regwrite = regwrite.
- Inputs are sampled only in IDLE. Upstream holds them stable while mem_stall=1; the block latches the address, size, unsigned flag, writereg and controls at request issue anyway.
- dmem_ack while IDLE (stale or after reset): ignored.
- rst during WAIT: req drops at the reset edge; a later ack is ignored.

Test Plan:
- add: alu_result=0x1234, regwrite=1, writereg=8 -> next edge wb_valid=1, wb_wdata=0x1234, wb_writereg=8; mem_stall never high.
- lb at 0x103, ack 1st WAIT cycle, rdata=0x80FF_0000 -> dmem_addr=0x100, be=0000 unused for read; wb_wdata=0xFFFFFF80. Repeat lbu -> 0x00000080. Exactly 1 stall cycle.
- sh store_data=0xABCD at 0x202 -> dmem_we=1, be=1100, wdata=0xABCDABCD; held stable across 3 no-ack cycles; stall until ack; wb_regwrite=0.
- lw at 0x105 -> no req, no stall, mem_misalign pulse, wb_regwrite=0.
- lw, ack never arrives, WAIT_LIMIT=4 -> req high 4 cycles then drops, mem_timeout pulse, stall released; later ack ignored.
- rst asserted in WAIT -> all outputs 0 after the edge; ack next cycle ignored; following lw completes normally.
